// File: rtl/mips_core_pkg.sv
// Shared core definitions: reorder-buffer instruction classes, entry layout and defaults.
package mips_core_pkg;

    localparam int unsigned ROB_DEPTH     = 16;
    localparam int unsigned ROB_COMMIT_W  = 2;
    localparam int unsigned ROB_DATA_W    = 32;
    localparam int unsigned ROB_ADDR_W    = 16;
    localparam int unsigned ROB_PREG_BITS = 6;

    typedef enum logic [1:0] {
        BR  = 2'd0,
        JU  = 2'd1,
        ST  = 2'd2,
        REG = 2'd3
    } rob_inst_t;

    typedef struct packed {
        logic                     valid;
        logic                     ready;
        rob_inst_t                itype;
        logic                     jump_reg;
        logic [ROB_PREG_BITS-1:0] preg;
        logic [4:0]               lreg;
        logic [ROB_DATA_W-1:0]    value;
        logic [ROB_ADDR_W-1:0]    addr;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Retire-group selection over the ROB head window: in-order ready prefix, one
// predictor update, at most one store, and store back-pressure.
module rob_commit_select
    import mips_core_pkg::*;
#(
    parameter int unsigned COMMIT_W = ROB_COMMIT_W
) (
    input  logic [COMMIT_W-1:0]      win_valid,
    input  logic [COMMIT_W-1:0]      win_ready,
    input  logic [COMMIT_W-1:0][1:0] win_type,
    input  logic [COMMIT_W-1:0]      win_jump_reg,
    input  logic                     mem_stall,
    output logic [COMMIT_W-1:0]      retire_mask
);

    logic stop;
    logic st_seen;

    always_comb begin
        retire_mask = '0;
        stop        = 1'b0;
        st_seen     = 1'b0;
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            if (!stop) begin
                if (!(win_valid[i] && win_ready[i])) begin
                    stop = 1'b1;
                end else if (rob_inst_t'(win_type[i]) == ST && (st_seen || mem_stall)) begin
                    stop = 1'b1;
                end else begin
                    retire_mask[i] = 1'b1;
                    if (rob_inst_t'(win_type[i]) == ST)
                        st_seen = 1'b1;
                    // a branch or jump-register closes the group after itself
                    if (rob_inst_t'(win_type[i]) == BR || win_jump_reg[i])
                        stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with single dispatch, multi-wide in-order commit, multi-port
// result write-back, store port, partial squash by branch tag and full flush.
module rob_multi_commit
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH     = ROB_DEPTH,
    parameter int unsigned COMMIT_W  = ROB_COMMIT_W,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned DATA_W    = ROB_DATA_W,
    parameter int unsigned ADDR_W    = ROB_ADDR_W,
    parameter int unsigned PREG_BITS = ROB_PREG_BITS,
    parameter int unsigned TAG_W     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_valid,
    input  logic [1:0]                    disp_type,
    input  logic                          disp_ready_init,
    input  logic                          disp_jump_reg,
    input  logic [PREG_BITS-1:0]          disp_preg,
    input  logic [4:0]                    disp_lreg,
    output logic                          disp_ready,
    output logic [TAG_W-1:0]              disp_tag,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
    input  logic                          st_valid,
    input  logic [TAG_W-1:0]              st_tag,
    input  logic [ADDR_W-1:0]             st_addr,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          mem_stall,
    input  logic                          flush_valid,
    input  logic [TAG_W-1:0]              flush_tag,
    input  logic                          full_flush,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W*2-1:0]         commit_type,
    output logic [COMMIT_W-1:0]           commit_jump_reg,
    output logic [COMMIT_W*PREG_BITS-1:0] commit_preg,
    output logic [COMMIT_W*5-1:0]         commit_lreg,
    output logic [COMMIT_W*DATA_W-1:0]    commit_data,
    output logic [COMMIT_W*ADDR_W-1:0]    commit_addr,
    output logic [TAG_W:0]                count,
    output logic                          empty
);

    // Parameterised form of rob_entry_t so non-default widths stay consistent.
    typedef struct packed {
        logic                 valid;
        logic                 ready;
        rob_inst_t            itype;
        logic                 jump_reg;
        logic [PREG_BITS-1:0] preg;
        logic [4:0]           lreg;
        logic [DATA_W-1:0]    value;
        logic [ADDR_W-1:0]    addr;
    } entry_t;

    entry_t                    mem [DEPTH];
    logic [TAG_W:0]            rd_ptr, wr_ptr;
    logic [TAG_W-1:0]          rd_idx, wr_idx;
    logic                      full, disp_fire;
    logic [TAG_W-1:0]          flush_off;
    logic [TAG_W:0]            flush_wr;
    logic [DEPTH-1:0]          squash;
    logic [TAG_W-1:0]          win_idx [COMMIT_W];
    logic [COMMIT_W-1:0]       win_valid, win_ready, win_jump_reg;
    logic [COMMIT_W-1:0][1:0]  win_type;
    logic [COMMIT_W-1:0]       retire_mask;
    logic [TAG_W:0]            n_commit;
    logic [TAG_W-1:0]          cdb_idx [CDB_PORTS];
    logic [CDB_PORTS-1:0]      cdb_hit;
    logic                      st_hit;

    assign rd_idx     = rd_ptr[TAG_W-1:0];
    assign wr_idx     = wr_ptr[TAG_W-1:0];
    assign full       = (rd_ptr[TAG_W] != wr_ptr[TAG_W]) && (rd_idx == wr_idx);
    assign empty      = (rd_ptr == wr_ptr);
    assign count      = wr_ptr - rd_ptr;
    assign disp_ready = !full;
    assign disp_tag   = wr_idx;
    assign disp_fire  = disp_valid && disp_ready && !flush_valid && !full_flush;

    // Squash everything strictly younger than the branch, by distance from the head.
    always_comb begin
        flush_off = flush_tag - rd_idx;
        flush_wr  = rd_ptr + {1'b0, flush_off} + (TAG_W+1)'(1);
        for (int unsigned j = 0; j < DEPTH; j++)
            squash[j] = flush_valid && ((TAG_W'(j) - rd_idx) > flush_off);
    end

    always_comb begin
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            cdb_idx[p] = cdb_tag[p*TAG_W +: TAG_W];
            cdb_hit[p] = cdb_valid[p] && mem[cdb_idx[p]].valid && !squash[cdb_idx[p]];
        end
        st_hit = st_valid && mem[st_tag].valid && !squash[st_tag];
    end

    always_comb begin
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            win_idx[i]      = rd_idx + TAG_W'(i);
            win_valid[i]    = mem[win_idx[i]].valid && !squash[win_idx[i]];
            win_ready[i]    = mem[win_idx[i]].ready;
            win_type[i]     = mem[win_idx[i]].itype;
            win_jump_reg[i] = mem[win_idx[i]].jump_reg;
            commit_type[i*2 +: 2]                = mem[win_idx[i]].itype;
            commit_jump_reg[i]                   = mem[win_idx[i]].jump_reg;
            commit_preg[i*PREG_BITS +: PREG_BITS] = mem[win_idx[i]].preg;
            commit_lreg[i*5 +: 5]                = mem[win_idx[i]].lreg;
            commit_data[i*DATA_W +: DATA_W]      = mem[win_idx[i]].value;
            commit_addr[i*ADDR_W +: ADDR_W]      = mem[win_idx[i]].addr;
        end
    end

    rob_commit_select #(
        .COMMIT_W (COMMIT_W)
    ) u_commit_select (
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_type     (win_type),
        .win_jump_reg (win_jump_reg),
        .mem_stall    (mem_stall),
        .retire_mask  (retire_mask)
    );

    always_comb begin
        n_commit = '0;
        for (int unsigned i = 0; i < COMMIT_W; i++)
            n_commit = n_commit + (TAG_W+1)'(retire_mask[i]);
    end

    assign commit_valid = full_flush ? '0 : retire_mask;

    // Later writes in this block take precedence: CDB, store, retire, squash, dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else if (full_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned j = 0; j < DEPTH; j++)
                mem[j] <= '0;
        end else begin
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (cdb_hit[p]) begin
                    mem[cdb_idx[p]].value <= cdb_data[p*DATA_W +: DATA_W];
                    mem[cdb_idx[p]].ready <= 1'b1;
                end
            end
            if (st_hit) begin
                mem[st_tag].addr  <= st_addr;
                mem[st_tag].value <= st_data;
                mem[st_tag].ready <= 1'b1;
            end
            for (int unsigned i = 0; i < COMMIT_W; i++) begin
                if (retire_mask[i]) begin
                    mem[win_idx[i]].valid <= 1'b0;
                    mem[win_idx[i]].ready <= 1'b0;
                end
            end
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (squash[j]) begin
                    mem[j].valid <= 1'b0;
                    mem[j].ready <= 1'b0;
                end
            end
            if (disp_fire) begin
                mem[wr_idx] <= '{valid: 1'b1, ready: disp_ready_init,
                                 itype: rob_inst_t'(disp_type), jump_reg: disp_jump_reg,
                                 preg: disp_preg, lreg: disp_lreg, value: '0, addr: '0};
            end
            rd_ptr <= rd_ptr + n_commit;
            if (flush_valid)
                wr_ptr <= flush_wr;
            else if (disp_fire)
                wr_ptr <= wr_ptr + (TAG_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed scenarios plus random traffic
// compared against a queue-based model of the reorder buffer.
module tb_rob_multi_commit;

    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int CP    = 2;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int PB    = 6;
    localparam int TW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_valid, disp_ready_init, disp_jump_reg;
    logic [1:0]        disp_type;
    logic [PB-1:0]     disp_preg;
    logic [4:0]        disp_lreg;
    logic              disp_ready;
    logic [TW-1:0]     disp_tag;
    logic [CP-1:0]     cdb_valid;
    logic [CP*TW-1:0]  cdb_tag;
    logic [CP*DW-1:0]  cdb_data;
    logic              st_valid;
    logic [TW-1:0]     st_tag;
    logic [AW-1:0]     st_addr;
    logic [DW-1:0]     st_data;
    logic              mem_stall, flush_valid, full_flush;
    logic [TW-1:0]     flush_tag;
    logic [CW-1:0]     commit_valid, commit_jump_reg;
    logic [CW*2-1:0]   commit_type;
    logic [CW*PB-1:0]  commit_preg;
    logic [CW*5-1:0]   commit_lreg;
    logic [CW*DW-1:0]  commit_data;
    logic [CW*AW-1:0]  commit_addr;
    logic [TW:0]       count;
    logic              empty;

    always #5 clk = ~clk;

    rob_multi_commit #(
        .DEPTH(DEPTH), .COMMIT_W(CW), .CDB_PORTS(CP), .DATA_W(DW),
        .ADDR_W(AW), .PREG_BITS(PB), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_ready_init(disp_ready_init),
        .disp_jump_reg(disp_jump_reg), .disp_preg(disp_preg), .disp_lreg(disp_lreg),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .st_valid(st_valid), .st_tag(st_tag), .st_addr(st_addr), .st_data(st_data),
        .mem_stall(mem_stall), .flush_valid(flush_valid), .flush_tag(flush_tag),
        .full_flush(full_flush),
        .commit_valid(commit_valid), .commit_type(commit_type),
        .commit_jump_reg(commit_jump_reg), .commit_preg(commit_preg),
        .commit_lreg(commit_lreg), .commit_data(commit_data), .commit_addr(commit_addr),
        .count(count), .empty(empty)
    );

    typedef struct {
        int          tag;
        bit [1:0]    ty;
        bit          jr;
        bit          rdy;
        bit [PB-1:0] preg;
        bit [4:0]    lreg;
        bit [DW-1:0] val;
        bit [AW-1:0] addr;
    } ent_t;

    ent_t q[$];   // oldest first
    int   wr_tag = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pos_of(input int t);
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == t) return i;
        return -1;
    endfunction

    // How many head entries retire this cycle, by the retirement rules.
    function automatic int exp_commit_n();
        int lim = q.size();
        int n = 0;
        bit st_seen = 0;
        if (flush_valid && pos_of(int'(flush_tag)) >= 0) lim = pos_of(int'(flush_tag)) + 1;
        while (n < CW && n < lim) begin
            if (!q[n].rdy) break;
            if (q[n].ty == 2'd2) begin
                if (st_seen || mem_stall) break;
                st_seen = 1;
            end
            n++;
            if (q[n-1].ty == 2'd0 || q[n-1].jr) break;
        end
        return n;
    endfunction

    task automatic model_update(input int n);
        int   sz0 = q.size();
        int   fp = -1;
        int   p;
        ent_t e;
        if (full_flush) begin
            q.delete();
            wr_tag = 0;
            return;
        end
        if (flush_valid) fp = pos_of(int'(flush_tag));
        for (int k = 0; k < CP; k++) begin
            if (cdb_valid[k]) begin
                p = pos_of(int'(cdb_tag[k*TW +: TW]));
                if (p >= 0 && (fp < 0 || p <= fp)) begin
                    e = q[p]; e.rdy = 1; e.val = cdb_data[k*DW +: DW]; q[p] = e;
                end
            end
        end
        if (st_valid) begin
            p = pos_of(int'(st_tag));
            if (p >= 0 && (fp < 0 || p <= fp)) begin
                e = q[p]; e.rdy = 1; e.val = st_data; e.addr = st_addr; q[p] = e;
            end
        end
        if (fp >= 0) begin
            while (q.size() > fp + 1) void'(q.pop_back());
            wr_tag = (int'(flush_tag) + 1) % DEPTH;
        end
        repeat (n) void'(q.pop_front());
        if (disp_valid && sz0 < DEPTH && !flush_valid) begin
            e.tag = wr_tag; e.ty = disp_type; e.jr = disp_jump_reg; e.rdy = disp_ready_init;
            e.preg = disp_preg; e.lreg = disp_lreg; e.val = '0; e.addr = '0;
            q.push_back(e);
            wr_tag = (wr_tag + 1) % DEPTH;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        int            n;
        logic [CW-1:0] ev;
        #1;
        n  = exp_commit_n();
        ev = '0;
        if (!full_flush)
            for (int i = 0; i < n; i++) ev[i] = 1'b1;
        check_eq("commit_valid", commit_valid, ev);
        for (int i = 0; i < CW; i++) begin
            if (ev[i]) begin
                check_eq("commit_type", commit_type[i*2 +: 2], q[i].ty);
                check_eq("commit_jump_reg", commit_jump_reg[i], q[i].jr);
                check_eq("commit_preg", commit_preg[i*PB +: PB], q[i].preg);
                check_eq("commit_lreg", commit_lreg[i*5 +: 5], q[i].lreg);
                check_eq("commit_data", commit_data[i*DW +: DW], q[i].val);
                check_eq("commit_addr", commit_addr[i*AW +: AW], q[i].addr);
            end
        end
        @(posedge clk);
        model_update(n);
        @(negedge clk);
        check_eq("count", count, q.size());
        check_eq("empty", empty, q.size() == 0);
        check_eq("disp_ready", disp_ready, q.size() < DEPTH);
        check_eq("disp_tag", disp_tag, wr_tag);
    endtask

    task automatic idle();
        disp_valid = 0; disp_type = 2'd3; disp_ready_init = 0; disp_jump_reg = 0;
        disp_preg = '0; disp_lreg = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        st_valid = 0; st_tag = '0; st_addr = '0; st_data = '0;
        mem_stall = 0; flush_valid = 0; flush_tag = '0; full_flush = 0;
    endtask

    task automatic disp(input logic [1:0] ty, input logic rinit);
        idle();
        disp_valid = 1; disp_type = ty; disp_ready_init = rinit;
        disp_preg = PB'($urandom); disp_lreg = 5'($urandom);
    endtask

    task automatic cdb0(input int t, input logic [DW-1:0] d);
        idle();
        cdb_valid = 2'b01; cdb_tag[TW-1:0] = TW'(t); cdb_data[DW-1:0] = d;
    endtask

    task automatic do_full_flush();
        idle(); full_flush = 1; step(); idle();
    endtask

    initial begin
        idle();
        rst = 1;
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_disp_ready", disp_ready, 1);
        check_eq("rst_disp_tag", disp_tag, 0);
        check_eq("rst_commit_valid", commit_valid, 0);
        @(negedge clk);
        rst = 0;

        // fill to capacity, then one more dispatch must be ignored
        for (int i = 0; i < DEPTH; i++) begin disp(2'd3, 0); step(); end
        check_eq("full_disp_ready", disp_ready, 0);
        disp(2'd3, 0); step();
        check_eq("full_count", count, DEPTH);
        cdb0(0, 32'h1234_5678); step();
        idle(); full_flush = 1; disp_valid = 1;
        #1 check_eq("ff_commit_valid", commit_valid, 0);
        step(); idle();
        check_eq("ff_count", count, 0);
        check_eq("ff_empty", empty, 1);

        // two-wide retire after out-of-order results
        for (int i = 0; i < 3; i++) begin disp(2'd3, 0); step(); end
        cdb0(1, 32'hAAAA_0001); step();
        cdb0(0, 32'hAAAA_0000); step();
        idle();
        #1 check_eq("two_wide", commit_valid, 2'b11);
        step();
        check_eq("two_wide_left", count, 1);
        do_full_flush();

        // store blocked by mem_stall, then store + reg together
        disp(2'd2, 0); step();
        disp(2'd3, 1); step();
        idle(); st_valid = 1; st_tag = 0; st_addr = 16'hBEEF; st_data = 32'hCAFE_F00D; step();
        idle(); mem_stall = 1;
        #1 check_eq("st_stall", commit_valid, 2'b00);
        step();
        idle();
        #1 check_eq("st_go", commit_valid, 2'b11);
        check_eq("st_slot0_type", commit_type[1:0], 2'd2);
        check_eq("st_slot1_type", commit_type[3:2], 2'd3);
        step();

        // branch closes the retire group
        disp(2'd0, 0); step();
        disp(2'd3, 1); step();
        cdb0(2, 32'h0000_0B0B); step();
        idle();
        #1 check_eq("br_alone", commit_valid, 2'b01);
        step();
        #1 check_eq("reg_after_br", commit_valid, 2'b01);
        check_eq("reg_after_br_type", commit_type[1:0], 2'd3);
        step();

        // partial squash with occupancy tags 5..10
        do_full_flush();
        for (int i = 0; i < 5; i++) begin disp(2'd3, 1); step(); end
        for (int i = 0; i < 6; i++) begin disp(2'd3, 0); step(); end
        idle(); step();
        check_eq("pre_flush_count", count, 6);
        idle(); flush_valid = 1; flush_tag = 4'd7;
        cdb_valid = 2'b01; cdb_tag[TW-1:0] = 4'd9; cdb_data[DW-1:0] = 32'hDEAD_0009;
        step();
        check_eq("flush_count", count, 3);
        check_eq("flush_next_tag", disp_tag, 8);
        disp(2'd3, 0); step();
        disp(2'd3, 0); step();
        cdb0(9, 32'h0000_0099); step();
        cdb0(5, 32'h0000_0055); step();
        cdb0(6, 32'h0000_0066); step();
        idle(); step(); step();
        do_full_flush();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle();
            r = $urandom_range(99);
            if (r < 2) full_flush = 1;
            else if (r < 6 && q.size() > 0) begin
                flush_valid = 1;
                flush_tag = TW'(q[$urandom_range(q.size() - 1)].tag);
            end
            disp_valid = ($urandom_range(99) < 60);
            disp_type = 2'($urandom);
            disp_ready_init = ($urandom_range(99) < 25);
            disp_jump_reg = (disp_type == 2'd1) && $urandom_range(1) == 1;
            disp_preg = PB'($urandom);
            disp_lreg = 5'($urandom);
            for (int k = 0; k < CP; k++) begin
                cdb_valid[k] = ($urandom_range(99) < 50);
                if (q.size() > 0 && $urandom_range(99) < 85)
                    cdb_tag[k*TW +: TW] = TW'(q[$urandom_range(q.size() - 1)].tag);
                else
                    cdb_tag[k*TW +: TW] = TW'($urandom);
                cdb_data[k*DW +: DW] = $urandom;
            end
            if (q.size() > 0) begin
                int p = $urandom_range(q.size() - 1);
                if (q[p].ty == 2'd2 && $urandom_range(99) < 60) begin
                    st_valid = 1; st_tag = TW'(q[p].tag);
                    st_addr = AW'($urandom); st_data = $urandom;
                end
            end
            mem_stall = ($urandom_range(99) < 30);
            step();
        end

        // asynchronous reset mid-stream, checked before any clock edge
        do_full_flush();
        for (int i = 0; i < 3; i++) begin disp(2'd3, 1); step(); end
        idle();
        #2 rst = 1;
        #1;
        check_eq("arst_count", count, 0);
        check_eq("arst_empty", empty, 1);
        check_eq("arst_commit_valid", commit_valid, 0);
        check_eq("arst_disp_tag", disp_tag, 0);
        q.delete();
        wr_tag = 0;
        @(negedge clk);
        rst = 0;
        disp(2'd3, 0); step();
        idle(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised next-generation reorder buffer: one dispatch per cycle, up to COMMIT_W in-order retirements per cycle, CDB_PORTS result write ports, and a separate store address/data port.
- Adds tag-based partial squash on branch mispredict, keeping the branch and everything older, alongside the existing full flush.
- Sits between decode/rename (dispatch side) and the architectural register file, store path and branch predictor (commit side).

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- COMMIT_W, 2, maximum retirements per cycle, range 1..4.
- CDB_PORTS, 2, number of result write-back ports.
- DATA_W, 32, value width.
- ADDR_W, 16, store address width.
- PREG_BITS, 6, physical register index width.
- TAG_W, $clog2(DEPTH), derived entry tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  1  dispatch request.
- disp_type  in  2  BR=0, JU=1, ST=2, REG=3.
- disp_ready_init  in  1  entry is ready at dispatch (direct jump).
- disp_jump_reg  in  1  entry is a jump-register.
- disp_preg  in  PREG_BITS  destination physical register.
- disp_lreg  in  5  destination logical register.
- disp_ready  out  1  ROB not full.
- disp_tag  out  TAG_W  tag assigned to the current dispatch.
- cdb_valid  in  CDB_PORTS  per-port result valid.
- cdb_tag  in  CDB_PORTS*TAG_W  per-port result tag.
- cdb_data  in  CDB_PORTS*DATA_W  per-port result value.
- st_valid  in  1  store address/data ready.
- st_tag  in  TAG_W  store entry tag.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- mem_stall  in  1  store port busy.
- flush_valid  in  1  partial squash request.
- flush_tag  in  TAG_W  tag of the mispredicted branch.
- full_flush  in  1  clear all entries.
- commit_valid  out  COMMIT_W  per-slot retire.
- commit_type  out  COMMIT_W*2  per-slot instruction type.
- commit_jump_reg  out  COMMIT_W  per-slot jump-register flag.
- commit_preg  out  COMMIT_W*PREG_BITS  per-slot physical destination.
- commit_lreg  out  COMMIT_W*5  per-slot logical destination.
- commit_data  out  COMMIT_W*DATA_W  per-slot value.
- commit_addr  out  COMMIT_W*ADDR_W  per-slot store address.
- count  out  TAG_W+1  occupancy.
- empty  out  1  occupancy is zero.

Behaviour:
- Pointers:
  - rd_ptr and wr_ptr are TAG_W+1 bits with a wrap bit.
  - full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - count = wr_ptr - rd_ptr.
- Reset (async, rst=1): all entries invalid, pointers 0. Outputs: commit_valid=0, disp_ready=1, disp_tag=0, count=0, empty=1.
- Dispatch:
  - Accepted when disp_valid & disp_ready & !flush_valid & !full_full_flush conditions hold, i.e. neither flush_valid nor full_flush is asserted.
  - Writes the entry at wr_ptr: valid=1, ready=disp_ready_init, type, jump_reg, preg, lreg; wr_ptr increments.
  - disp_ready depends on registered state only; a slot freed by commit in the same cycle is not reusable until the next cycle.
- CDB:
  - Each valid port writes value and sets ready=1 on its tag, but only if that entry is valid.
  - If two ports hit the same tag, the higher port index wins.
  - st_valid writes addr, data and ready=1 at st_tag.
- Commit (combinational from registered state; visible in the same cycle it is computed):
  - The retire group is the longest prefix of valid and ready entries starting at rd_ptr, capped at COMMIT_W entries.
  - The group ends after the first BR or jump_reg entry, so at most one predictor update occurs per cycle.
  - The group holds at most one ST.
  - A ST in the group with mem_stall=1 is not retired, and neither is anything after it; entries before it still retire.
  - Retired entries are cleared at the clock edge and rd_ptr advances by the group size.
  - A result written by the CDB this cycle becomes retireable from the next cycle.
- Partial flush (flush_valid):
  - flush_tag lies within the occupied range.
  - wr_ptr <= rd_ptr + ((flush_tag - rd_ptr[TAG_W-1:0]) mod DEPTH) + 1, where rd_ptr is the pre-commit value.
  - Entries younger than flush_tag are invalidated.
  - Commits in the same cycle proceed normally.
  - CDB and store writes to squashed tags in the same cycle are dropped.
- Full flush:
  - Has priority over flush_valid and dispatch.
  - Clears all entries and sets both pointers to 0.
  - commit_valid is forced to 0 in that cycle.
- Dispatch at the wrap boundary: tag DEPTH-1 is followed by tag 0, and the wrap bit toggles.

Decomposition:
- Shared package (mips_core_pkg) holds:
  - the rob_inst_t enum {BR, JU, ST, REG};
  - the rob_entry_t struct {valid, ready, type, jump_reg, preg, lreg, value, addr};
  - ROB_DEPTH and ROB_COMMIT_W defaults.
- One combinational sub-module, rob_commit_select, computes the per-slot retire mask from the head window plus mem_stall.

Test Plan:
- Reset, then dispatch 16 REG ops with no CDB → disp_ready=0 at count=16; a 17th dispatch is ignored; count stays 16.
- Dispatch REG tags 0-2, CDB writes tags 1 and 0 over two cycles → the cycle after tag 0 is written, commit_valid=2'b11 (tags 0,1); tag 2 is not retired.
- Head ST ready, next REG ready, mem_stall=1 → commit_valid=0; drop mem_stall → ST in slot 0, REG in slot 1.
- Ready BR then ready REG at head → only the BR retires in cycle N; the REG retires in N+1.
- Occupancy tags 5..10 (rd=5), flush_valid with flush_tag=7 → count=3 next cycle; the next dispatch receives tag 8; a CDB write to tag 9 in the flush cycle is ignored.
- Assert full_flush while head ready and a dispatch is pending → commit_valid=0, then count=0, empty=1; an async rst mid-stream clears outputs without a clock edge.
